// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: read-data owner tags and
// the CPU wait-counter width.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PPU  = 2'd2
    } owner_e;

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational winner select: CPU first during blanking, PPU first during
// active display unless the CPU has already waited CPU_MAX_WAIT cycles.
module vram_arb_pick
    import vram_arb_pkg::*;
#(
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic              blank,
    input  logic              cpu_req,
    input  logic              ppu_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output owner_e            winner
);

    always_comb begin
        winner = OWN_NONE;
        if (blank) begin
            if (cpu_req) begin
                winner = OWN_CPU;
            end else if (ppu_req) begin
                winner = OWN_PPU;
            end
        end else if (cpu_req && (!ppu_req || wait_cnt >= WAIT_W'(CPU_MAX_WAIT))) begin
            winner = OWN_CPU;
        end else if (ppu_req) begin
            winner = OWN_PPU;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between CPU (read/write) and PPU (read-only) with a
// registered RAM interface and a 2-deep owner pipeline steering read data.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blank,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    output logic [DATA_W-1:0] ppu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [WAIT_W-1:0] cpu_stall_max
);

    owner_e            winner;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic              ram_we_q,     ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;
    owner_e            own0_q,       own0_d;
    owner_e            own1_q,       own1_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic              ppu_rvalid_q, ppu_rvalid_d;
    logic [DATA_W-1:0] ppu_rdata_q,  ppu_rdata_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic [WAIT_W-1:0] stall_max_q,  stall_max_d;

    vram_arb_pick #(
        .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) u_pick (
        .blank    (blank),
        .cpu_req  (cpu_req),
        .ppu_req  (ppu_req),
        .wait_cnt (wait_cnt_q),
        .winner   (winner)
    );

    // Grants are masked while reset is held so every output reads 0 in reset.
    always_comb begin
        cpu_gnt = rst_n && (winner == OWN_CPU);
        ppu_gnt = rst_n && (winner == OWN_PPU);
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        own0_d      = OWN_NONE;
        if (cpu_gnt) begin
            ram_addr_d = cpu_addr;
            ram_we_d   = cpu_we;
            if (cpu_we) begin
                ram_wdata_d = cpu_wdata;
            end else begin
                own0_d = OWN_CPU;
            end
        end else if (ppu_gnt) begin
            ram_addr_d = ppu_addr;
            own0_d     = OWN_PPU;
        end
        own1_d = own0_q;

        cpu_rvalid_d = (own1_q == OWN_CPU);
        ppu_rvalid_d = (own1_q == OWN_PPU);
        cpu_rdata_d  = cpu_rvalid_d ? ram_rdata : cpu_rdata_q;
        ppu_rdata_d  = ppu_rvalid_d ? ram_rdata : ppu_rdata_q;

        if (cpu_req && !cpu_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
        stall_max_d = (wait_cnt_d > stall_max_q) ? wait_cnt_d : stall_max_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            own0_q       <= OWN_NONE;
            own1_q       <= OWN_NONE;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ppu_rvalid_q <= 1'b0;
            ppu_rdata_q  <= '0;
            wait_cnt_q   <= '0;
            stall_max_q  <= '0;
        end else begin
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            own0_q       <= own0_d;
            own1_q       <= own1_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ppu_rvalid_q <= ppu_rvalid_d;
            ppu_rdata_q  <= ppu_rdata_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_max_q  <= stall_max_d;
        end
    end

    always_comb begin
        ram_addr      = ram_addr_q;
        ram_we        = ram_we_q;
        ram_wdata     = ram_wdata_q;
        cpu_rvalid    = cpu_rvalid_q;
        cpu_rdata     = cpu_rdata_q;
        ppu_rvalid    = ppu_rvalid_q;
        ppu_rdata     = ppu_rdata_q;
        cpu_stall_max = stall_max_q;
    end

endmodule
